dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep sequencer for the `dds` phase-accumulator/sine-ROM block. It latches a sweep configuration on a start pulse and steps the DDS tuning word from a start to a stop frequency. The DDS clock-enable is driven through a programmable prescaler, and each frequency is held for a programmable number of enabled ticks. Its outputs connect directly to `FreqWord` and `ClkEn` of `dds`. The DDS is fed `PhaseShift` elsewhere.

## Interface
- `PHASE_W`, default 24: tuning-word width. Must match the `dds` instance.
- `DWELL_W`, default 16: dwell counter width.
- `PRESC_W`, default 8: prescaler width.

- `clk`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle request to begin a sweep. Sampled only in IDLE.
- `abort`, in, 1: stop the sweep immediately.
- `cfg_f_start`, in, PHASE_W: first tuning word.
- `cfg_f_stop`, in, PHASE_W: last allowed tuning word (inclusive).
- `cfg_f_step`, in, PHASE_W: increment per step, unsigned.
- `cfg_dwell`, in, DWELL_W: enabled ticks held per frequency. A value of 0 is treated as 1.
- `cfg_presc`, in, PRESC_W: `ClkEn` period minus 1.
- `cfg_repeat`, in, 1: 0 = single sweep, 1 = restart at `cfg_f_start` after the last step.
- `freq_word`, out, PHASE_W: drives `dds.FreqWord`.
- `clk_en`, out, 1: drives `dds.ClkEn`.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse when a single sweep completes normally.

## Operation
- **States.** There are two states, IDLE and RUN.
  - `cfg_*` inputs are latched into shadow registers on the IDLE→RUN transition.
  - Changes to `cfg_*` during RUN have no effect.
- **IDLE.**
  - Outputs: `freq_word`=0, `clk_en`=0, `busy`=0.
  - `start`=1 and `abort`=0 → RUN.
  - `start` and `abort` asserted in the same cycle: `abort` wins and the block stays in IDLE.
- **RUN.**
  - `freq_word` = current word `cur`, loaded from `f_start` on entry.
  - A prescaler counts 0..`presc` and restarts at 0 on entry to RUN.
  - `clk_en` = 1 when the prescaler equals `presc`.
  - A dwell counter counts `clk_en` ticks.
- **End of dwell.** On the tick that completes the dwell, compute `nxt` = `cur` + `step` at PHASE_W+1 bits.
  - If `step`≠0 and `nxt` ≤ `f_stop`, with no carry out of PHASE_W: `cur` ← `nxt`, the dwell counter restarts, and the state stays RUN.
  - Otherwise the sweep is terminal:
    - `repeat`=1: `cur` ← `f_start` and the state stays RUN.
    - `repeat`=0: → IDLE, `done` pulses.
- **Wrap-around.** The tuning word never wraps modulo 2^PHASE_W. A carry out of PHASE_W is treated as exceeding `f_stop`.
- **`f_start` > `f_stop`.** Exactly one dwell is performed at `f_start`, then the sweep terminates.
- **`abort` in RUN.** → IDLE on the next edge. No `done` pulse. `freq_word` and `clk_en` go to 0.
- **`rst`.** Forces IDLE, clears all counters, and zeroes every output (`freq_word`, `clk_en`, `busy`, `done`). This holds in every state, including mid-sweep.

## Timing
- `start` sampled at edge N → `busy`=1 and `freq_word`=`f_start` from cycle N+1.
- First `clk_en` occurs at cycle N+1+`presc`.
- Each word is held for exactly `dwell`×(`presc`+1) cycles.
- The new `freq_word` appears in the cycle after the final dwell tick.
- On a terminal single sweep, `done`=1 and `busy`=0 in the same cycle, which is the first IDLE cycle. `freq_word`=0 in that cycle.
- A `start` asserted in the `done` cycle is accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `dds_pkg` holds:
  - the state enum `sweep_state_t` {IDLE, RUN};
  - the default `PHASE_W` = 24, shared with `dds`.
- Sub-module `dds_tick_gen`: prescaler with `clr` and `presc` inputs and a `tick` output. Instantiated once.
- The top level contains the FSM, the shadow config registers, the dwell counter and the PHASE_W+1 adder/compare.

## Test plan
- **Basic sweep.** start=100, stop=130, step=10, dwell=3, presc=0, repeat=0.
  - `freq_word` must be 100,100,100,110,…,130 (12 cycles).
  - `done` pulses at cycle N+13 and `busy` drops in the same cycle.
- **Prescaler.** presc=2, dwell=2, start=5, step=5, stop=10.
  - `clk_en` pattern must be 0,0,1 repeating.
  - Each word is held 6 cycles.
  - `done` occurs 12 cycles after RUN entry.
- **Repeat mode.** Same configuration as the basic sweep with repeat=1.
  - After 130, `freq_word` returns to 100 with no IDLE gap.
  - `done` is never asserted.
  - `abort` then gives IDLE next cycle, with `freq_word`=0 and no `done`.
- **Overflow and degenerate cases.**
  - start=0xFFFFF0, step=0x20, stop=0xFFFFFF: one dwell at 0xFFFFF0, then `done`; the word must not wrap.
  - start=200, stop=100: one dwell, then `done`.
  - step=0: one dwell, then `done`.
- **Handshake edges.**
  - `start` during RUN is ignored.
  - `start`+`abort` asserted together in IDLE leaves the block in IDLE.
  - `start` in the `done` cycle begins a new sweep at N+1.
  - Changing `cfg_*` mid-sweep has no effect.
- **Reset mid-sweep.**
  - `rst` asserted in the 5th cycle of RUN → all outputs 0 on the next cycle.
  - A following `start` runs a correct full sweep.

Source files
------------

// File: rtl/dds_pkg.sv
// Types and defaults shared by the DDS block family.
// Keep DDS_PHASE_W in step with the dds phase accumulator.
package dds_pkg;

   localparam int DDS_PHASE_W = 24;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between a sweep requester and dds_sweep_ctrl.
// The master requests sweeps; the slave is the sequencer itself.
interface dds_sweep_ctrl_if #(
   parameter int PHASE_W = dds_pkg::DDS_PHASE_W,
   parameter int DWELL_W = 16,
   parameter int PRESC_W = 8
);

   logic               start;
   logic               abort;
   logic [PHASE_W-1:0] cfg_f_start;
   logic [PHASE_W-1:0] cfg_f_stop;
   logic [PHASE_W-1:0] cfg_f_step;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [PRESC_W-1:0] cfg_presc;
   logic               cfg_repeat;
   logic [PHASE_W-1:0] freq_word;
   logic               clk_en;
   logic               busy;
   logic               done;

   modport master (
      output start, abort,
      output cfg_f_start, cfg_f_stop, cfg_f_step,
      output cfg_dwell, cfg_presc, cfg_repeat,
      input  freq_word, clk_en, busy, done
   );

   modport slave (
      input  start, abort,
      input  cfg_f_start, cfg_f_stop, cfg_f_step,
      input  cfg_dwell, cfg_presc, cfg_repeat,
      output freq_word, clk_en, busy, done
   );

endinterface

// File: rtl/dds_tick_gen.sv
// Prescaler producing a registered one-cycle tick every presc+1 cycles.
// The tick is registered from the next count so it lines up with the count.
module dds_tick_gen #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] r_cnt;
   logic [PRESC_W-1:0] w_cnt_nxt;
   logic               r_tick;

   always_comb begin
      w_cnt_nxt = (r_cnt == presc) ? '0 : PRESC_W'(r_cnt + 1'b1);
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (clr) begin
         r_cnt  <= '0;
         r_tick <= (presc == '0);
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_tick <= (w_cnt_nxt == presc);
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving FreqWord/ClkEn of a dds instance.
// Config is shadowed at sweep start; the word never wraps past 2^PHASE_W.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int PHASE_W = DDS_PHASE_W,
   parameter int DWELL_W = 16,
   parameter int PRESC_W = 8
) (
   input logic             clk,
   input logic             rst,
   dds_sweep_ctrl_if.slave sweep
);

   sweep_state_t       r_state;
   logic [PHASE_W-1:0] r_f_start;
   logic [PHASE_W-1:0] r_f_stop;
   logic [PHASE_W-1:0] r_f_step;
   logic [DWELL_W-1:0] r_dwell_last;
   logic [PRESC_W-1:0] r_presc;
   logic               r_repeat;
   logic [PHASE_W-1:0] r_cur;
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic               r_busy;
   logic               r_done;

   logic [PHASE_W:0]   w_nxt;
   logic [PRESC_W-1:0] w_presc;
   logic               w_tick;
   logic               w_accept;
   logic               w_can_step;
   logic               w_dwell_end;
   logic               w_finish;
   logic               w_run_nxt;
   logic               w_idle;

   // Extra bit catches a carry so an overflowing step counts as past f_stop.
   always_comb begin
      w_idle      = (r_state == IDLE);
      w_nxt       = {1'b0, r_cur} + {1'b0, r_f_step};
      w_can_step  = (r_f_step != '0) && !w_nxt[PHASE_W]
                 && (w_nxt[PHASE_W-1:0] <= r_f_stop);
      w_dwell_end = w_tick && (r_dwell_cnt == r_dwell_last);
      w_accept    = w_idle && sweep.start && !sweep.abort;
      w_finish    = w_dwell_end && !w_can_step && !r_repeat;
      w_run_nxt   = w_idle ? w_accept : !(sweep.abort || w_finish);
      w_presc     = w_idle ? sweep.cfg_presc : r_presc;
   end

   dds_tick_gen #(
      .PRESC_W(PRESC_W)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_idle),
      .en   (w_run_nxt),
      .presc(w_presc),
      .tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_f_start    <= '0;
         r_f_stop     <= '0;
         r_f_step     <= '0;
         r_dwell_last <= '0;
         r_presc      <= '0;
         r_repeat     <= 1'b0;
         r_cur        <= '0;
         r_dwell_cnt  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_f_start    <= sweep.cfg_f_start;
                  r_f_stop     <= sweep.cfg_f_stop;
                  r_f_step     <= sweep.cfg_f_step;
                  r_dwell_last <= (sweep.cfg_dwell == '0) ? '0
                                : DWELL_W'(sweep.cfg_dwell - 1'b1);
                  r_presc      <= sweep.cfg_presc;
                  r_repeat     <= sweep.cfg_repeat;
                  r_cur        <= sweep.cfg_f_start;
                  r_dwell_cnt  <= '0;
                  r_busy       <= 1'b1;
                  r_state      <= RUN;
               end
            end
            RUN: begin
               if (sweep.abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_cur   <= '0;
               end else if (w_dwell_end) begin
                  r_dwell_cnt <= '0;
                  if (w_can_step) begin
                     r_cur <= w_nxt[PHASE_W-1:0];
                  end else if (r_repeat) begin
                     r_cur <= r_f_start;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_cur   <= '0;
                     r_done  <= 1'b1;
                  end
               end else if (w_tick) begin
                  r_dwell_cnt <= DWELL_W'(r_dwell_cnt + 1'b1);
               end
            end
         endcase
      end
   end

   assign sweep.freq_word = r_cur;
   assign sweep.clk_en    = w_tick;
   assign sweep.busy      = r_busy;
   assign sweep.done      = r_done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: word-list model checked every cycle,
// plus directed literal checks at hand-derived cycles.
module tb_dds_sweep_ctrl;

   localparam int PW = 24;
   localparam int DW = 16;
   localparam int SW = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dds_sweep_ctrl_if #(
      .PHASE_W(PW), .DWELL_W(DW), .PRESC_W(SW)
   ) bus ();

   dds_sweep_ctrl #(
      .PHASE_W(PW), .DWELL_W(DW), .PRESC_W(SW)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .sweep(bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: the sweep is a list of words, each held for hold cycles.
   longint        m_list[$];
   bit            m_run = 1'b0;
   bit            m_rep = 1'b0;
   int            m_k = 0;
   int            m_hold = 1;
   int            m_p = 0;
   logic [PW-1:0] e_freq = '0;
   logic          e_en = 1'b0;
   logic          e_busy = 1'b0;
   logic          e_done = 1'b0;
   bit            cmp_on = 1'b0;

   always @(posedge clk) begin
      longint w;
      longint st;
      longint sp;
      int     d;
      e_done = 1'b0;
      if (rst) begin
         m_run = 1'b0;
      end else if (m_run) begin
         if (bus.abort) begin
            m_run = 1'b0;
         end else begin
            m_k++;
            if (m_k == m_hold * m_list.size()) begin
               if (m_rep) m_k = 0;
               else begin
                  m_run  = 1'b0;
                  e_done = 1'b1;
               end
            end
         end
      end else if (bus.start && !bus.abort) begin
         m_list.delete();
         w  = longint'(bus.cfg_f_start);
         st = longint'(bus.cfg_f_step);
         sp = longint'(bus.cfg_f_stop);
         m_list.push_back(w);
         while (st != 0 && w + st <= sp) begin
            w = w + st;
            m_list.push_back(w);
         end
         d      = (bus.cfg_dwell == '0) ? 1 : int'(bus.cfg_dwell);
         m_p    = int'(bus.cfg_presc);
         m_hold = d * (m_p + 1);
         m_rep  = bus.cfg_repeat;
         m_k    = 0;
         m_run  = 1'b1;
      end
      e_busy = m_run;
      e_freq = m_run ? PW'(m_list[m_k / m_hold]) : '0;
      e_en   = m_run && ((m_k % (m_p + 1)) == m_p);
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("freq_word", 64'(bus.freq_word), 64'(e_freq));
         chk("clk_en", 64'(bus.clk_en), 64'(e_en));
         chk("busy", 64'(bus.busy), 64'(e_busy));
         chk("done", 64'(bus.done), 64'(e_done));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cfg(input logic [PW-1:0] fs,
                          input logic [PW-1:0] fe,
                          input logic [PW-1:0] st,
                          input logic [DW-1:0] dw,
                          input logic [SW-1:0] pr,
                          input logic rep);
      bus.cfg_f_start = fs;
      bus.cfg_f_stop  = fe;
      bus.cfg_f_step  = st;
      bus.cfg_dwell   = dw;
      bus.cfg_presc   = pr;
      bus.cfg_repeat  = rep;
   endtask

   // Leaves the bench in cycle N+1, start having been sampled at edge N.
   task automatic pulse_start();
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 1'b0);
      tick(3);
      cmp_on = 1'b1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_freq", 64'(bus.freq_word), 64'd0);
      rst = 1'b0;
      tick(2);

      // basic sweep
      set_cfg(100, 130, 10, 3, 0, 1'b0);
      pulse_start();
      chk("b_f0", 64'(bus.freq_word), 64'd100);
      chk("b_busy", 64'(bus.busy), 64'd1);
      tick(3);
      chk("b_f1", 64'(bus.freq_word), 64'd110);
      tick(9);
      chk("b_done", 64'(bus.done), 64'd1);
      chk("b_busy0", 64'(bus.busy), 64'd0);
      chk("b_fz", 64'(bus.freq_word), 64'd0);

      // start in the done cycle, then cfg churn and start while running
      pulse_start();
      chk("r_f0", 64'(bus.freq_word), 64'd100);
      chk("r_nodone", 64'(bus.done), 64'd0);
      tick(2);
      set_cfg(7, 9000, 1, 1, 0, 1'b1);
      pulse_start();
      chk("r_f1", 64'(bus.freq_word), 64'd110);
      tick(9);
      chk("r_done", 64'(bus.done), 64'd1);
      tick(2);

      // prescaler
      set_cfg(5, 10, 5, 2, 2, 1'b0);
      pulse_start();
      chk("p_en1", 64'(bus.clk_en), 64'd0);
      tick(1);
      chk("p_en2", 64'(bus.clk_en), 64'd0);
      tick(1);
      chk("p_en3", 64'(bus.clk_en), 64'd1);
      tick(4);
      chk("p_f1", 64'(bus.freq_word), 64'd10);
      tick(6);
      chk("p_done", 64'(bus.done), 64'd1);
      tick(2);

      // repeat mode, then abort
      set_cfg(100, 130, 10, 3, 0, 1'b1);
      pulse_start();
      tick(12);
      chk("rp_wrap", 64'(bus.freq_word), 64'd100);
      chk("rp_busy", 64'(bus.busy), 64'd1);
      tick(10);
      bus.abort = 1'b1;
      tick(1);
      bus.abort = 1'b0;
      chk("ab_busy", 64'(bus.busy), 64'd0);
      chk("ab_freq", 64'(bus.freq_word), 64'd0);
      chk("ab_done", 64'(bus.done), 64'd0);
      tick(2);

      // carry out of the word width
      set_cfg(24'hFFFFF0, 24'hFFFFFF, 24'h20, 1, 0, 1'b0);
      pulse_start();
      chk("ov_f0", 64'(bus.freq_word), 64'hFFFFF0);
      tick(1);
      chk("ov_done", 64'(bus.done), 64'd1);
      tick(2);

      // start above stop
      set_cfg(200, 100, 10, 2, 1, 1'b0);
      pulse_start();
      tick(4);
      chk("rv_done", 64'(bus.done), 64'd1);
      tick(2);

      // zero step, zero dwell
      set_cfg(50, 100, 0, 0, 0, 1'b0);
      pulse_start();
      chk("z_f0", 64'(bus.freq_word), 64'd50);
      tick(1);
      chk("z_done", 64'(bus.done), 64'd1);
      tick(2);

      // start with abort in IDLE
      set_cfg(100, 130, 10, 3, 0, 1'b0);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick(1);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("sa_busy", 64'(bus.busy), 64'd0);
      tick(2);

      // reset in the 5th RUN cycle
      pulse_start();
      tick(4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rs_freq", 64'(bus.freq_word), 64'd0);
      chk("rs_busy", 64'(bus.busy), 64'd0);
      chk("rs_en", 64'(bus.clk_en), 64'd0);
      tick(1);
      pulse_start();
      chk("rs_f0", 64'(bus.freq_word), 64'd100);
      tick(12);
      chk("rs_done", 64'(bus.done), 64'd1);
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
